// File: rtl/skin_pkg.sv
// Shared defaults for the skin classifier and the downstream tracker:
// YCbCr thresholds, position/counter widths and a range-compare helper.
package skin_pkg;

    localparam logic [7:0] CB_MIN_DEF = 8'd77;
    localparam logic [7:0] CB_MAX_DEF = 8'd127;
    localparam logic [7:0] CR_MIN_DEF = 8'd133;
    localparam logic [7:0] CR_MAX_DEF = 8'd173;
    localparam logic [7:0] Y_MIN_DEF  = 8'd16;
    localparam int         POS_W_DEF  = 11;
    localparam int         CNT_W_DEF  = 22;

    // Unsigned inclusive range test used for both chroma channels.
    function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/skin_bbox_acc.sv
// Per-frame skin pixel counter and bounding-box accumulator; latches the
// finished frame into the stats outputs on each vsync rising edge.
module skin_bbox_acc
    import skin_pkg::*;
#(
    parameter int POS_W = POS_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             skin,
    input  logic             vsync,
    input  logic [POS_W-1:0] x,
    input  logic [POS_W-1:0] y,
    output logic [CNT_W-1:0] skin_count,
    output logic [POS_W-1:0] bbox_xmin,
    output logic [POS_W-1:0] bbox_xmax,
    output logic [POS_W-1:0] bbox_ymin,
    output logic [POS_W-1:0] bbox_ymax,
    output logic             stats_valid
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             vs_prev_r;
    logic             frame_seen_r;
    logic [CNT_W-1:0] cnt_r;
    logic [POS_W-1:0] xmin_r, xmax_r, ymin_r, ymax_r;
    logic             vs_rise_s;
    logic             load_s;

    assign vs_rise_s = vsync & ~vs_prev_r;
    // A skin pixel on the boundary cycle opens the new frame rather than joining the old one.
    assign load_s    = skin & (vs_rise_s | (cnt_r == '0));

    // Accumulate skin statistics and publish them at frame boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_r    <= 1'b0;
            frame_seen_r <= 1'b0;
            cnt_r        <= '0;
            xmin_r       <= '0;
            xmax_r       <= '0;
            ymin_r       <= '0;
            ymax_r       <= '0;
            skin_count   <= '0;
            bbox_xmin    <= '0;
            bbox_xmax    <= '0;
            bbox_ymin    <= '0;
            bbox_ymax    <= '0;
            stats_valid  <= 1'b0;
        end else if (ce) begin
            vs_prev_r   <= vsync;
            stats_valid <= 1'b0;
            if (vs_rise_s) begin
                if (frame_seen_r) begin
                    skin_count  <= cnt_r;
                    bbox_xmin   <= xmin_r;
                    bbox_xmax   <= xmax_r;
                    bbox_ymin   <= ymin_r;
                    bbox_ymax   <= ymax_r;
                    stats_valid <= 1'b1;
                end
                frame_seen_r <= 1'b1;
            end
            if (load_s) begin
                cnt_r  <= CNT_ONE;
                xmin_r <= x;
                xmax_r <= x;
                ymin_r <= y;
                ymax_r <= y;
            end else if (vs_rise_s) begin
                cnt_r  <= '0;
                xmin_r <= '0;
                xmax_r <= '0;
                ymin_r <= '0;
                ymax_r <= '0;
            end else if (skin) begin
                cnt_r  <= (cnt_r == '1) ? cnt_r : cnt_r + CNT_ONE;
                xmin_r <= (x < xmin_r) ? x : xmin_r;
                xmax_r <= (x > xmax_r) ? x : xmax_r;
                ymin_r <= (y < ymin_r) ? y : ymin_r;
                ymax_r <= (y > ymax_r) ? y : ymax_r;
            end
        end else begin
            stats_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/skin_detect.sv
// Two-stage YCbCr skin classifier with sync alignment, pixel position
// tracking and per-frame skin statistics.
module skin_detect
    import skin_pkg::*;
#(
    parameter logic [7:0] CB_MIN = CB_MIN_DEF,
    parameter logic [7:0] CB_MAX = CB_MAX_DEF,
    parameter logic [7:0] CR_MIN = CR_MIN_DEF,
    parameter logic [7:0] CR_MAX = CR_MAX_DEF,
    parameter logic [7:0] Y_MIN  = Y_MIN_DEF,
    parameter int         POS_W  = POS_W_DEF,
    parameter int         CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             de_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic [7:0]       Y,
    input  logic [7:0]       Cb,
    input  logic [7:0]       Cr,
    output logic             skin,
    output logic             de_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic [CNT_W-1:0] skin_count,
    output logic [POS_W-1:0] bbox_xmin,
    output logic [POS_W-1:0] bbox_xmax,
    output logic [POS_W-1:0] bbox_ymin,
    output logic [POS_W-1:0] bbox_ymax,
    output logic             stats_valid
);

    localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

    logic             de_prev_r, vs_prev_r;
    logic [POS_W-1:0] x_r, y_r;
    logic [POS_W-1:0] x_cur_s, y_next_s;
    logic             cb_ok_r, cr_ok_r, y_ok_r;
    logic             de1_r, hs1_r, vs1_r;
    logic [POS_W-1:0] x1_r, y1_r, x2_r, y2_r;

    // Position of the incoming pixel and the line counter's next value.
    always_comb begin
        x_cur_s  = '0;
        y_next_s = y_r;
        if (de_in && de_prev_r) begin
            x_cur_s = (x_r == '1) ? x_r : x_r + POS_ONE;
        end else begin
            x_cur_s = '0;
        end
        if (vsync_in && !vs_prev_r) begin
            y_next_s = '0;
        end else if (de_prev_r && !de_in) begin
            y_next_s = (y_r == '1) ? y_r : y_r + POS_ONE;
        end else begin
            y_next_s = y_r;
        end
    end

    // Input edge detectors, position counters and both pipeline stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_prev_r <= 1'b0;
            vs_prev_r <= 1'b0;
            x_r       <= '0;
            y_r       <= '0;
            cb_ok_r   <= 1'b0;
            cr_ok_r   <= 1'b0;
            y_ok_r    <= 1'b0;
            de1_r     <= 1'b0;
            hs1_r     <= 1'b0;
            vs1_r     <= 1'b0;
            x1_r      <= '0;
            y1_r      <= '0;
            skin      <= 1'b0;
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            x2_r      <= '0;
            y2_r      <= '0;
        end else if (ce) begin
            de_prev_r <= de_in;
            vs_prev_r <= vsync_in;
            x_r       <= x_cur_s;
            y_r       <= y_next_s;
            cb_ok_r   <= in_range(Cb, CB_MIN, CB_MAX);
            cr_ok_r   <= in_range(Cr, CR_MIN, CR_MAX);
            y_ok_r    <= (Y >= Y_MIN);
            de1_r     <= de_in;
            hs1_r     <= hsync_in;
            vs1_r     <= vsync_in;
            x1_r      <= x_cur_s;
            y1_r      <= y_r;
            skin      <= cb_ok_r & cr_ok_r & y_ok_r & de1_r;
            de_out    <= de1_r;
            hsync_out <= hs1_r;
            vsync_out <= vs1_r;
            x2_r      <= x1_r;
            y2_r      <= y1_r;
        end
    end

    skin_bbox_acc #(
        .POS_W (POS_W),
        .CNT_W (CNT_W)
    ) u_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .skin        (skin),
        .vsync       (vsync_out),
        .x           (x2_r),
        .y           (y2_r),
        .skin_count  (skin_count),
        .bbox_xmin   (bbox_xmin),
        .bbox_xmax   (bbox_xmax),
        .bbox_ymin   (bbox_ymin),
        .bbox_ymax   (bbox_ymax),
        .stats_valid (stats_valid)
    );

endmodule

// File: tb/tb_skin_detect.sv
// Scoreboard bench for skin_detect: expected pixel outputs and frame stats
// are queued when stimulus is driven and compared when the DUT produces them.
module tb_skin_detect;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic        de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic [7:0]  Y = 8'd0, Cb = 8'd0, Cr = 8'd0;
    logic        skin, de_out, hsync_out, vsync_out, stats_valid;
    logic [21:0] skin_count;
    logic [10:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;

    int          n_total = 0;
    int          n_bad = 0;
    bit          tog = 1'b0;
    logic [3:0]  exp_q[$];
    logic [3:0]  exp_now = 4'd0;
    logic [65:0] st_q[$];

    always #5 clk = ~clk;

    skin_detect dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .de_in       (de_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .Y           (Y),
        .Cb          (Cb),
        .Cr          (Cr),
        .skin        (skin),
        .de_out      (de_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .skin_count  (skin_count),
        .bbox_xmin   (bbox_xmin),
        .bbox_xmax   (bbox_xmax),
        .bbox_ymin   (bbox_ymin),
        .bbox_ymax   (bbox_ymax),
        .stats_valid (stats_valid)
    );

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_skin(input logic [7:0] yy, input logic [7:0] cbv,
                                      input logic [7:0] crv, input logic d);
        return d && (cbv >= 8'd77) && (cbv <= 8'd127) && (crv >= 8'd133) &&
               (crv <= 8'd173) && (yy >= 8'd16);
    endfunction

    // One clock: drive inputs, then compare the outputs after the edge.
    task automatic step(input logic c, input logic d, input logic h, input logic v,
                        input logic [7:0] yy, input logic [7:0] cbv, input logic [7:0] crv);
        logic [65:0] st;
        ce = c; de_in = d; hsync_in = h; vsync_in = v; Y = yy; Cb = cbv; Cr = crv;
        @(posedge clk);
        #1;
        if (c) begin
            exp_q.push_back({ref_skin(yy, cbv, crv, d), d, h, v});
            exp_now = exp_q.pop_front();
        end
        chk("pipe", {68'd0, skin, de_out, hsync_out, vsync_out}, {68'd0, exp_now});
        if (!c) chk("sv_ce0", {71'd0, stats_valid}, 72'd0);
        if (stats_valid) begin
            if (st_q.size() == 0) begin
                chk("sv_unexp", {71'd0, stats_valid}, 72'd0);
            end else begin
                st = st_q.pop_front();
                chk("cnt",  {50'd0, skin_count}, {50'd0, st[65:44]});
                chk("xmin", {61'd0, bbox_xmin},  {61'd0, st[43:33]});
                chk("xmax", {61'd0, bbox_xmax},  {61'd0, st[32:22]});
                chk("ymin", {61'd0, bbox_ymin},  {61'd0, st[21:11]});
                chk("ymax", {61'd0, bbox_ymax},  {61'd0, st[10:0]});
            end
        end
    endtask

    task automatic px(input logic d, input logic h, input logic v, input logic sk);
        logic [7:0] cbv;
        cbv = sk ? 8'd100 : 8'd50;
        step(1'b1, d, h, v, 8'h50, cbv, 8'd150);
        if (tog) step(1'b0, d, h, v, 8'h50, cbv, 8'd150);
    endtask

    task automatic vsync_pulse();
        for (int i = 0; i < 2; i++) px(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) px(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Four lines of eight pixels; skin at (2,1) and (5,3) when with_skin is set.
    task automatic frame(input bit with_skin);
        logic sk;
        for (int l = 0; l < 4; l++) begin
            px(1'b0, 1'b1, 1'b0, 1'b0);
            px(1'b0, 1'b0, 1'b0, 1'b0);
            for (int x = 0; x < 8; x++) begin
                sk = with_skin && ((x == 2 && l == 1) || (x == 5 && l == 3));
                px(1'b1, 1'b0, 1'b0, sk);
            end
            px(1'b0, 1'b0, 1'b0, 1'b0);
            px(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    logic [7:0] sw_y[10]  = '{8'h50, 8'h50, 8'h50, 8'h50, 8'h50, 8'h50, 8'h50, 8'h50, 8'd15, 8'd16};
    logic [7:0] sw_cb[10] = '{8'd76, 8'd77, 8'd127, 8'd128, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    logic [7:0] sw_cr[10] = '{8'd150, 8'd150, 8'd150, 8'd150, 8'd132, 8'd133, 8'd173, 8'd174, 8'd150, 8'd150};

    initial begin
        ce = 1'b1; de_in = 1'b1; Y = 8'h50; Cb = 8'd100; Cr = 8'd150;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix", {68'd0, skin, de_out, hsync_out, vsync_out, 1'b0}, 72'd0);
        chk("rst_st", {5'd0, skin_count, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, stats_valid}, 72'd0);
        ce = 1'b0; de_in = 1'b0;
        rst_n = 1'b1;
        exp_q.push_back(4'd0);

        // First pixel: visible after exactly two enabled clocks.
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h50, 8'd100, 8'd150);
        chk("lat1_skin", {71'd0, skin}, 72'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h50, 8'd100, 8'd150);
        chk("lat2_skin", {70'd0, skin, de_out}, 72'd3);

        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, sw_y[i], sw_cb[i], sw_cr[i]);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h50, 8'd100, 8'd150);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h50, 8'd100, 8'd150);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h50, 8'd100, 8'd150);

        // Opening vsync must not publish stats.
        vsync_pulse();
        frame(1'b1);
        st_q.push_back({22'd2, 11'd2, 11'd5, 11'd1, 11'd3});
        vsync_pulse();
        chk("sv_seen1", {40'd0, st_q.size()}, 72'd0);

        frame(1'b0);
        st_q.push_back(66'd0);
        vsync_pulse();
        chk("sv_seen0", {40'd0, st_q.size()}, 72'd0);

        tog = 1'b1;
        frame(1'b1);
        st_q.push_back({22'd2, 11'd2, 11'd5, 11'd1, 11'd3});
        vsync_pulse();
        chk("sv_seen_ce", {40'd0, st_q.size()}, 72'd0);
        tog = 1'b0;
        px(1'b0, 1'b0, 1'b0, 1'b0);
        chk("hold_cnt", {50'd0, skin_count}, 72'd2);

        // Reset in the middle of a frame with skin pixels in flight.
        px(1'b0, 1'b1, 1'b0, 1'b0);
        px(1'b1, 1'b0, 1'b0, 1'b1);
        px(1'b1, 1'b0, 1'b0, 1'b1);
        ce = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstm_pix", {68'd0, skin, de_out, hsync_out, vsync_out, 1'b0}, 72'd0);
        chk("rstm_st", {5'd0, skin_count, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, stats_valid}, 72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_q.push_back(4'd0);
        exp_now = 4'd0;
        px(1'b1, 1'b0, 1'b0, 1'b1);
        px(1'b0, 1'b0, 1'b0, 1'b0);
        vsync_pulse();
        frame(1'b1);
        st_q.push_back({22'd2, 11'd2, 11'd5, 11'd1, 11'd3});
        vsync_pulse();
        chk("sv_seen_rst", {40'd0, st_q.size()}, 72'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/skin_detect.md
Name: skin_detect

Overview:
- Per-pixel skin classifier sitting directly downstream of rgb2ycbcr.
- Consumes Y/Cb/Cr plus delayed de/hsync/vsync and emits a 1-bit skin mask with timing-aligned syncs.
- Accumulates per-frame statistics: skin pixel count and bounding box. These are latched at each frame boundary for the downstream tracking/neuro stage.

Parameters:
- CB_MIN, 77, inclusive lower Cb bound
- CB_MAX, 127, inclusive upper Cb bound
- CR_MIN, 133, inclusive lower Cr bound
- CR_MAX, 173, inclusive upper Cr bound
- Y_MIN, 16, inclusive lower luma bound (rejects near-black)
- POS_W, 11, width of x/y position counters
- CNT_W, 22, width of skin pixel counter

Ports:
- clk, in, 1, pixel clock
- rst_n, in, 1, asynchronous active-low reset
- ce, in, 1, clock enable; all state advances only when ce=1
- de_in, in, 1, data enable from rgb2ycbcr (active high)
- hsync_in, in, 1, hsync from rgb2ycbcr (active high)
- vsync_in, in, 1, vsync from rgb2ycbcr (active high)
- Y, in, 8, luma
- Cb, in, 8, blue-difference chroma
- Cr, in, 8, red-difference chroma
- skin, out, 1, mask bit; 1 = skin pixel, forced 0 when de_out=0
- de_out, out, 1, de delayed to match skin
- hsync_out, out, 1, hsync delayed to match skin
- vsync_out, out, 1, vsync delayed to match skin
- skin_count, out, CNT_W, skin pixels in last complete frame
- bbox_xmin, out, POS_W, leftmost skin x in last frame
- bbox_xmax, out, POS_W, rightmost skin x in last frame
- bbox_ymin, out, POS_W, top skin y in last frame
- bbox_ymax, out, POS_W, bottom skin y in last frame
- stats_valid, out, 1, one-cycle pulse when the stats outputs update

Behaviour:
- Reset (rst_n=0, async): every output 0; all pipeline, position, accumulator and edge-detect registers 0; frame_seen=0.
- Reset mid-frame: the partial frame is discarded; the first vsync rising edge after reset only arms frame_seen.
- ce=0: every register holds and stats_valid stays 0. Latency is counted in ce=1 cycles.
- Pipeline, 2 stages, latency 2:
  - Stage 1 registers the compare results (Cb in [CB_MIN,CB_MAX], Cr in [CR_MIN,CR_MAX], Y>=Y_MIN), the syncs, x and y.
  - Stage 2 registers skin = AND of all compares AND de.
  - de/hsync/vsync_out are delayed exactly 2.
  - All compares are unsigned, with inclusive bounds.
- Position tracking, on the stage-1 input side:
  - x: 0 on the first de=1 cycle of a line; +1 each subsequent de=1 cycle; saturates at all-ones.
  - y: +1 on each de falling edge; saturates at all-ones; cleared to 0 on vsync rising edge.
- Accumulators, updated from stage 2:
  - On a skin=1 cycle: count+1, saturating at 2^CNT_W-1; xmin=min, xmax=max, ymin=min, ymax=max.
  - When acc count=0, the first skin pixel loads all four bbox registers directly.
- Frame boundary (vsync_out rising edge at stage 2):
  - If frame_seen=1: copy accumulators to the stats outputs and pulse stats_valid for 1 cycle. A frame with zero skin pixels outputs count=0 and bbox all 0.
  - Set frame_seen=1, then clear the accumulators.
  - If skin=1 on the same cycle as the vsync edge, that pixel belongs to the new frame: the accumulator is loaded with it, not cleared to empty.
- The stats outputs hold between pulses.

Decomposition:
- Shared package skin_pkg holds the default threshold constants (CB/CR/Y bounds) and the POS_W/CNT_W defaults, so the classifier and the downstream tracker agree.
- One natural sub-module: skin_bbox_acc (count plus min/max accumulator with frame latch). The classifier pipeline stays in the top.

Test Plan:
- Reset then Y=0x50, Cb=100, Cr=150, de=1 for 1 cycle (ce=1) -> skin=1 and de_out=1 exactly 2 cycles later; all outputs 0 during reset.
- Boundary sweep with Y=0x50, Cr=150, Cb=76/77/127/128 -> skin=0/1/1/0. Repeat with Cr=132/133/173/174 -> 0/1/1/0. Y=15/16 with in-range chroma -> 0/1.
- Same in-range pixel with de=0 -> skin=0, syncs still delayed by 2.
- Frame of 4 lines x 8 pixels, skin only at (x=2,y=1) and (x=5,y=3), bracketed by vsync pulses. Second vsync -> stats_valid 1 cycle, skin_count=2, bbox=(2,5,1,3). The first vsync gives no pulse.
- ce toggled 1/0 each cycle during the same frame -> identical stats; latency is 2 ce cycles; no stats_valid while ce=0.
- Zero-skin frame -> stats_valid with count=0, bbox 0. rst_n asserted mid-frame -> outputs 0 immediately, and no pulse on the first following vsync.
